card_shoe: RTL and testbench

//  Parametrised multi-deck card shoe: holds NUM_DECKS x 52 cards of card_t, performs an unbiased
//  in-place Fisher-Yates shuffle driven by an internal LFSR, then deals cards one per accepted draw.

---
 rtl/card_shoe.sv | 124 ++++++++++++
 tb/tb_card_shoe.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/card_shoe.sv
// Multi-deck card shoe: Fisher-Yates shuffle driven by a free-running LFSR, then
// deals one card per accepted draw and flags when the cut card has been reached.
//
// Ports:
//   clk, reset       clock, synchronous active-high reset
//   start_shuffle    pulse: return all cards and shuffle
//   draw             consume card_out (only while card_valid)
//   card_out         card at the deal pointer
//   card_valid       dealing and at least one card left
//   ready            in DEAL state
//   empty            dealing and no cards left
//   cards_remaining  undealt cards
//   reshuffle_due    dealing and cards_remaining at or below the cut depth

package card_pkg;
    typedef struct packed {
        logic [3:0] rank;
        logic [1:0] suit;
    } card_t;
endpackage

module card_shoe
    import card_pkg::*;
#(
    parameter int          NUM_DECKS  = 1,
    parameter int          CUT_REMAIN = 13,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1,
    localparam int         N          = 52 * NUM_DECKS,
    localparam int         CW         = $clog2(N + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start_shuffle,
    input  logic          draw,
    output card_t         card_out,
    output logic          card_valid,
    output logic          ready,
    output logic          empty,
    output logic [CW-1:0] cards_remaining,
    output logic          reshuffle_due
);

    localparam int            IDX_W = $clog2(N);
    localparam int            CUT_C = (CUT_REMAIN > N) ? N : CUT_REMAIN;
    localparam logic [CW-1:0] CUT_V = CW'(CUT_C);
    localparam logic [CW-1:0] N_V   = CW'(N);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SHUF = 2'd1;
    localparam logic [1:0] S_DEAL = 2'd2;

    logic [1:0]       state;
    logic [15:0]      lfsr;
    logic [15:0]      lfsr_next;
    logic [CW-1:0]    ptr;
    logic [IDX_W-1:0] i_idx;
    logic [IDX_W-1:0] j_idx;
    logic             accept;
    logic             take;
    card_t            shoe [N];

    // Galois form of x^16+x^14+x^13+x^11+1
    assign lfsr_next = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);

    // Out-of-range candidates are rejected rather than folded, keeping the
    // permutation unbiased at the cost of variable shuffle latency.
    assign j_idx  = lfsr[IDX_W-1:0];
    assign accept = (j_idx <= i_idx);

    assign cards_remaining = N_V - ptr;
    assign ready           = (state == S_DEAL);
    assign card_valid      = ready && (cards_remaining != '0);
    assign empty           = ready && (cards_remaining == '0);
    assign reshuffle_due   = ready && (CUT_REMAIN != 0) &&
                             (cards_remaining <= CUT_V);
    assign take            = draw && card_valid;

    assign card_out = (ptr < N_V) ? shoe[ptr[IDX_W-1:0]] : shoe[0];

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
            lfsr  <= LFSR_SEED;
            ptr   <= '0;
            i_idx <= '0;
            for (int k = 0; k < N; k++) begin
                shoe[k] <= '{rank: 4'(k % 13), suit: 2'((k / 13) % 4)};
            end
        end else begin
            lfsr <= lfsr_next;
            unique case (state)
                S_IDLE: begin
                    if (start_shuffle) begin
                        state <= S_SHUF;
                        i_idx <= IDX_W'(N - 1);
                        ptr   <= '0;
                    end
                end
                S_SHUF: begin
                    if (accept) begin
                        shoe[i_idx] <= shoe[j_idx];
                        shoe[j_idx] <= shoe[i_idx];
                        i_idx       <= i_idx - 1'b1;
                        if (i_idx == IDX_W'(1)) begin
                            state <= S_DEAL;
                        end
                    end
                end
                S_DEAL: begin
                    // A shuffle request wins over a simultaneous draw.
                    if (start_shuffle) begin
                        state <= S_SHUF;
                        i_idx <= IDX_W'(N - 1);
                        ptr   <= '0;
                    end else if (take) begin
                        ptr <= ptr + 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_card_shoe.sv
// Bench for card_shoe: reference shuffle model feeds an expected-card queue
// that is popped as cards are dealt; one- and two-deck instances.

module tb_card_shoe;
    import card_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic ss1 = 1'b0, dr1 = 1'b0, ss2 = 1'b0, dr2 = 1'b0;
    card_t co1, co2;
    logic v1, r1, e1, d1, v2, r2, e2, d2;
    logic [5:0] rem1;
    logic [6:0] rem2;

    always #5 clk = ~clk;

    card_shoe #(.NUM_DECKS(1), .CUT_REMAIN(13), .LFSR_SEED(16'hACE1)) u1 (
        .clk(clk), .reset(reset), .start_shuffle(ss1), .draw(dr1),
        .card_out(co1), .card_valid(v1), .ready(r1), .empty(e1),
        .cards_remaining(rem1), .reshuffle_due(d1)
    );

    card_shoe #(.NUM_DECKS(2), .CUT_REMAIN(13), .LFSR_SEED(16'hACE1)) u2 (
        .clk(clk), .reset(reset), .start_shuffle(ss2), .draw(dr2),
        .card_out(co2), .card_valid(v2), .ready(r2), .empty(e2),
        .cards_remaining(rem2), .reshuffle_due(d2)
    );

    int total = 0;
    int bad = 0;
    int nn[2] = '{52, 104};
    card_t mdeck[2][208];
    card_t exp_q[$];
    int obs_q[$];
    int run_q[$];
    int tally[64];
    int same;
    logic [15:0] m_lfsr;

    function automatic logic [15:0] lstep(input logic [15:0] l);
        return {1'b0, l[15:1]} ^ (l[0] ? 16'hB400 : 16'h0000);
    endfunction

    always @(posedge clk) m_lfsr <= reset ? 16'hACE1 : lstep(m_lfsr);

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic card_t idc(input int k);
        card_t c;
        c.rank = 4'(k % 13);
        c.suit = 2'((k / 13) % 4);
        return c;
    endfunction

    function automatic int rdy(input int d); return d == 0 ? int'(r1) : int'(r2); endfunction
    function automatic int val(input int d); return d == 0 ? int'(v1) : int'(v2); endfunction
    function automatic int emp(input int d); return d == 0 ? int'(e1) : int'(e2); endfunction
    function automatic int due(input int d); return d == 0 ? int'(d1) : int'(d2); endfunction
    function automatic int rem(input int d); return d == 0 ? int'(rem1) : int'(rem2); endfunction
    function automatic int crd(input int d); return d == 0 ? int'(co1) : int'(co2); endfunction

    function automatic int ident_bad();
        int b = 0;
        for (int k = 0; k < 52; k++) if (u1.shoe[k] != idc(k)) b++;
        for (int k = 0; k < 104; k++) if (u2.shoe[k] != idc(k)) b++;
        return b;
    endfunction

    function automatic int multiset_bad(input int nd);
        int b = 0;
        for (int r = 0; r < 13; r++)
            for (int s = 0; s < 4; s++)
                if (tally[r * 4 + s] != nd) b++;
        return b;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int d, input bit s, input bit w);
        if (d == 0) begin ss1 = s; dr1 = w; end
        else begin ss2 = s; dr2 = w; end
    endtask

    task automatic reset_chk();
        reset = 1'b1;
        tick();
        check("rst_ready1", int'(r1), 0);
        check("rst_ready2", int'(r2), 0);
        check("rst_valid1", int'(v1), 0);
        check("rst_rem1", int'(rem1), 52);
        check("rst_rem2", int'(rem2), 104);
        check("rst_ident", ident_bad(), 0);
        check("rst_card0", int'(co1), int'(idc(0)));
        reset = 1'b0;
        for (int d = 0; d < 2; d++)
            for (int k = 0; k < 208; k++) mdeck[d][k] = idc(k);
        exp_q.delete();
    endtask

    task automatic do_shuffle(input int d, input bit with_draw, input bit restart);
        int n, mask, i, j, k, cyc;
        logic [15:0] l;
        card_t t;
        n = nn[d];
        mask = (d == 0) ? 63 : 127;
        drive(d, 1'b1, with_draw);
        tick();
        drive(d, 1'b0, 1'b0);
        check("shuf_rdy0", rdy(d), 0);
        check("shuf_rem", rem(d), n);
        l = m_lfsr;
        i = n - 1;
        k = 0;
        while (i > 0) begin
            j = int'(l) & mask;
            if (j <= i) begin
                t = mdeck[d][i];
                mdeck[d][i] = mdeck[d][j];
                mdeck[d][j] = t;
                i--;
            end
            l = lstep(l);
            k++;
        end
        exp_q.delete();
        for (int p = 0; p < n; p++) exp_q.push_back(mdeck[d][p]);
        cyc = 0;
        while (!rdy(d) && cyc < 8 * n) begin
            if (restart && cyc == 5) drive(d, 1'b1, 1'b0);
            tick();
            drive(d, 1'b0, 1'b0);
            cyc++;
        end
        check("shuf_cycles", cyc, k);
        check("shuf_ready", rdy(d), 1);
        check("deal_rem", rem(d), n);
    endtask

    task automatic deal(input int d, input int cnt);
        int r, c;
        card_t e;
        for (int q = 0; q < cnt; q++) begin
            r = rem(d);
            check("valid", val(d), 1);
            c = crd(d);
            if (exp_q.size() == 0) begin
                check("exp_q_empty", 0, 1);
            end else begin
                e = exp_q.pop_front();
                check("card", c, int'(e));
            end
            obs_q.push_back(c);
            tally[c]++;
            if (c == int'(idc(nn[d] - r))) same++;
            drive(d, 1'b0, 1'b1);
            tick();
            drive(d, 1'b0, 1'b0);
            check("rem", rem(d), r - 1);
            check("due", due(d), (r - 1 <= 13) ? 1 : 0);
        end
    endtask

    initial begin
        tick();
        reset_chk();
        check("shoe51", int'(u1.shoe[51]), int'(idc(51)));

        foreach (tally[k]) tally[k] = 0;
        same = 0;
        do_shuffle(0, 1'b0, 1'b0);
        deal(0, 52);
        check("not_ident", (same < 52) ? 1 : 0, 1);
        check("multiset1", multiset_bad(1), 0);
        check("empty", emp(0), 1);
        check("valid_empty", val(0), 0);
        check("rem_empty", rem(0), 0);
        drive(0, 1'b0, 1'b1);
        tick();
        drive(0, 1'b0, 1'b0);
        check("rem_extra", rem(0), 0);
        check("ptr_extra", int'(u1.ptr), 52);
        check("due_empty", due(0), 1);

        foreach (tally[k]) tally[k] = 0;
        do_shuffle(1, 1'b0, 1'b0);
        deal(1, 104);
        check("multiset2", multiset_bad(2), 0);
        check("empty2", emp(1), 1);

        do_shuffle(0, 1'b0, 1'b1);
        deal(0, 10);
        do_shuffle(0, 1'b1, 1'b0);
        deal(0, 5);

        reset_chk();
        drive(0, 1'b1, 1'b0);
        tick();
        drive(0, 1'b0, 1'b0);
        repeat (20) tick();
        reset_chk();

        obs_q.delete();
        do_shuffle(0, 1'b0, 1'b0);
        deal(0, 52);
        run_q = obs_q;
        obs_q.delete();
        reset_chk();
        do_shuffle(0, 1'b0, 1'b0);
        deal(0, 52);
        check("determ_len", obs_q.size(), run_q.size());
        for (int p = 0; p < obs_q.size() && p < run_q.size(); p++)
            check("determ", obs_q[p], run_q[p]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
